alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised WIDTH-bit ALU with a registered result, replacing the per-bit ripple slice chain with a single block.
- Keeps the operand-invert, AND/OR/ADD/SLT/XOR operation set.
- Adds a shift-add multi-cycle unsigned multiply, a Start/Busy/Done handshake and registered Zero/CarryOut/Overflow flags.
- Sits between the register-file read ports and the write-back mux in the 24-bit datapath.

Parameters:
- WIDTH, 24, operand/result width in bits, minimum 2.
- MUL_EN, 1, 1 enables the MUL op; 0 makes Op 5 behave as a reserved op.

Ports:
- Clock  input  1  rising-edge clock.
- ResetN  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only while not Busy.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- AInvert  input  1  use ~A.
- BInvert  input  1  use ~B; also forces adder carry-in to 1.
- Op  input  3  0 AND, 1 OR, 2 ADD, 3 SLT, 4 XOR, 5 MUL, 6/7 reserved.
- Result  output  WIDTH  registered result.
- Zero  output  1  Result == 0, registered with Result.
- CarryOut  output  1  adder carry-out (ADD/SLT), else 0.
- Overflow  output  1  signed overflow (ADD/SLT); unsigned product overflow (MUL); else 0.
- Busy  output  1  MUL in progress.
- Done  output  1  one-cycle pulse when Result and flags update.

Behaviour:
Reset:
- ResetN low asynchronously clears Result, all flags, Busy and Done, and forces state IDLE.
- Reset asserted mid-MUL aborts the multiply; no Done is produced for the aborted op.

Operand conditioning and adder:
- mA = AInvert ? ~A : A; mB = BInvert ? ~B : B. Both are latched when Start is accepted.
- Adder computes sum = mA + mB + BInvert at WIDTH+1 bits.
- CarryOut = bit WIDTH of that sum.
- Overflow = (mA[MSB] == mB[MSB]) && (sum[MSB] != mA[MSB]).

Operations:
- AND, OR, XOR are bitwise on mA and mB.
- ADD: Result = sum[WIDTH-1:0]. Subtraction is ADD with BInvert=1.
- SLT: Result = {0…, sum[MSB] ^ Overflow}. Signed-correct only with BInvert=1. CarryOut and Overflow report the subtract.
- Reserved ops (and Op 5 when MUL_EN=0): Result = 0, Zero = 1, Done still pulses.

State machine: IDLE, MUL_RUN.
- IDLE with Start=1 sampled at edge k, non-MUL op:
  - Result, flags and Done=1 are visible after edge k (latency 1). State stays IDLE.
- IDLE with Start=1 sampled at edge k, MUL op:
  - Latch mA as multiplicand and mB as multiplier.
  - Clear the 2·WIDTH accumulator, set count = WIDTH, go to MUL_RUN.
  - Busy = 1 from after edge k.
- MUL_RUN, each edge:
  - If the multiplier LSB is 1, add the multiplicand shifted by the step index into the accumulator.
  - Shift the multiplier right and decrement count.
  - The step that takes count to 0 returns to IDLE, loads Result = acc[WIDTH-1:0], sets Overflow = |acc[2W-1:W], sets CarryOut = 0, and pulses Done.
  - Done is therefore visible after edge k+WIDTH. Busy is high for exactly WIDTH cycles.
- Start while Busy is ignored; operands, Op and invert inputs may change freely during MUL_RUN.
- Start sampled in the cycle Done is high is accepted (the state is IDLE), so back-to-back ops are allowed.
- Done is high for exactly one cycle per accepted Start.
- Result and all flags hold their values between completions. Zero always reflects the held Result.

Test Plan:
- Reset with ResetN=0 mid-run, then release → Result=0, flags=0, Busy=0, Done=0.
- ADD: A=0xFFFFFF, B=0x000001 → after 1 cycle Result=0x000000, Zero=1, CarryOut=1, Overflow=0, Done pulses once.
- ADD: A=0x7FFFFF, B=1 → Result=0x800000, Overflow=1. SUB (BInvert=1): A=5, B=7 → Result=0xFFFFFE, CarryOut=0.
- SLT (BInvert=1): A=0xFFFFFD (−3), B=2 → Result=1; A=2, B=0xFFFFFD → Result=0, Zero=1.
- MUL: A=1000, B=3000 → Busy for 24 cycles, Done after edge k+24, Result=0x2DC6C0, Overflow=0. A Start pulse at cycle 10 is ignored. A=0x1000, B=0x1000 → Result=0, Zero=1, Overflow=1.
- Back-to-back: XOR A=0xAAAAAA, B=0x555555 issued in the Done cycle of a MUL → Result=0xFFFFFF one cycle later. Assert ResetN low at MUL cycle 12 → no Done, Busy=0 immediately.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register-file read ports and the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 24
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             AInvert;
    logic             BInvert;
    logic [2:0]       Op;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             CarryOut;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, A, B, AInvert, BInvert, Op,
        input  Result, Zero, CarryOut, Overflow, Busy, Done
    );

    modport slave (
        input  Start, A, B, AInvert, BInvert, Op,
        output Result, Zero, CarryOut, Overflow, Busy, Done
    );
endinterface

// File: rtl/alu_seq.sv
// WIDTH-bit ALU with registered result and flags; single-cycle logic/add ops
// and a WIDTH-cycle shift-add unsigned multiply.
module alu_seq #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned MUL_EN = 1
) (
    input  logic     Clock,
    input  logic     ResetN,
    alu_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpAnd = 3'd0;
    localparam logic [2:0] OpOr  = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpSlt = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpMul = 3'd5;

    typedef enum logic [0:0] {StIdle, StMulRun} state_e;

    state_e             r_state, w_state_d;
    logic [WIDTH-1:0]   r_result, w_result_d;
    logic               r_zero;
    logic               r_carry, w_carry_d;
    logic               r_ovf, w_ovf_d;
    logic               r_done, w_done_d;
    logic [2*WIDTH-1:0] r_mcand, w_mcand_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    logic [WIDTH-1:0]   r_mplier, w_mplier_d;
    logic [CW-1:0]      r_count, w_count_d;

    logic [WIDTH-1:0]   w_ma, w_mb;
    logic [WIDTH:0]     w_sum;
    logic               w_add_ovf;
    logic               w_is_mul;
    logic [2*WIDTH-1:0] w_acc_add;

    // Operand conditioning, shared adder and the multiply accumulate step
    always_comb begin
        w_ma      = bus.AInvert ? ~bus.A : bus.A;
        w_mb      = bus.BInvert ? ~bus.B : bus.B;
        w_sum     = {1'b0, w_ma} + {1'b0, w_mb} + {{WIDTH{1'b0}}, bus.BInvert};
        w_add_ovf = (w_ma[WIDTH-1] == w_mb[WIDTH-1]) && (w_sum[WIDTH-1] != w_ma[WIDTH-1]);
        w_is_mul  = (MUL_EN != 0) && (bus.Op == OpMul);
        // Multiplicand is pre-shifted each step, so it already sits at the step index
        w_acc_add = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    // Next-state and next-result selection
    always_comb begin
        w_state_d  = r_state;
        w_result_d = r_result;
        w_carry_d  = r_carry;
        w_ovf_d    = r_ovf;
        w_done_d   = 1'b0;
        w_mcand_d  = r_mcand;
        w_mplier_d = r_mplier;
        w_acc_d    = r_acc;
        w_count_d  = r_count;

        case (r_state)
            StIdle: begin
                if (bus.Start) begin
                    if (w_is_mul) begin
                        w_mcand_d  = {{WIDTH{1'b0}}, w_ma};
                        w_mplier_d = w_mb;
                        w_acc_d    = '0;
                        w_count_d  = CW'(WIDTH);
                        w_state_d  = StMulRun;
                    end else begin
                        w_done_d  = 1'b1;
                        w_carry_d = 1'b0;
                        w_ovf_d   = 1'b0;
                        case (bus.Op)
                            OpAnd: w_result_d = w_ma & w_mb;
                            OpOr:  w_result_d = w_ma | w_mb;
                            OpXor: w_result_d = w_ma ^ w_mb;
                            OpAdd: begin
                                w_result_d = w_sum[WIDTH-1:0];
                                w_carry_d  = w_sum[WIDTH];
                                w_ovf_d    = w_add_ovf;
                            end
                            OpSlt: begin
                                // True sign of the subtract, corrected for overflow
                                w_result_d = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
                                w_carry_d  = w_sum[WIDTH];
                                w_ovf_d    = w_add_ovf;
                            end
                            default: w_result_d = '0;
                        endcase
                    end
                end
            end
            StMulRun: begin
                w_acc_d    = w_acc_add;
                w_mcand_d  = r_mcand << 1;
                w_mplier_d = r_mplier >> 1;
                w_count_d  = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_d  = StIdle;
                    w_result_d = w_acc_add[WIDTH-1:0];
                    w_ovf_d    = |w_acc_add[2*WIDTH-1:WIDTH];
                    w_carry_d  = 1'b0;
                    w_done_d   = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_result <= w_result_d;
            r_zero   <= (w_result_d == '0);
            r_carry  <= w_carry_d;
            r_ovf    <= w_ovf_d;
            r_done   <= w_done_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            r_acc    <= w_acc_d;
            r_count  <= w_count_d;
        end
    end

    assign bus.Result   = r_result;
    assign bus.Zero     = r_zero;
    assign bus.CarryOut = r_carry;
    assign bus.Overflow = r_ovf;
    assign bus.Busy     = (r_state == StMulRun);
    assign bus.Done     = r_done;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq with a queue-based scoreboard.
module tb_alu_seq;
    localparam int unsigned W = 24;

    logic Clock = 1'b0;
    logic ResetN;

    always #5 Clock = ~Clock;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the conditioned operands
    function automatic exp_t model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit ai, input bit bi);
        exp_t         e;
        logic [W-1:0] ma, mb;
        longint       ua, ub, sa, sb, s, ss, p, smax, smin;
        ma   = ai ? ~a : a;
        mb   = bi ? ~b : b;
        ua   = longint'(ma);
        ub   = longint'(mb);
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        s    = ua + ub + longint'(bi);
        ss   = sa + sb + longint'(bi);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        e.c  = 1'b0;
        e.v  = 1'b0;
        case (op)
            0: e.res = ma & mb;
            1: e.res = ma | mb;
            4: e.res = ma ^ mb;
            2, 3: begin
                e.res = (op == 2) ? W'(s) : ((ss < 0) ? W'(1) : W'(0));
                e.c   = (s >= (longint'(1) << W));
                e.v   = (ss > smax) || (ss < smin);
            end
            5: begin
                p     = ua * ub;
                e.res = W'(p);
                e.v   = ((p >> W) != 0);
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge Clock) begin
        if (ResetN === 1'b1 && bus.Done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("sb_result", bus.Result, mon_e.res);
                chk("sb_zero", bus.Zero, mon_e.z);
                chk("sb_carry", bus.CarryOut, mon_e.c);
                chk("sb_ovf", bus.Overflow, mon_e.v);
            end
        end
    end

    // Issue one op; MUL waits for Done. spoil/abort give the MUL cycle for a stray
    // Start pulse or a reset (-1 for none).
    task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit ai, input bit bi, input int spoil, input int abort);
        int busy_n;
        int cyc;
        bit seen;
        bus.A       = a;
        bus.B       = b;
        bus.AInvert = ai;
        bus.BInvert = bi;
        bus.Op      = 3'(op);
        bus.Start   = 1'b1;
        q.push_back(model(op, a, b, ai, bi));
        @(posedge Clock);
        #1;
        bus.Start = 1'b0;
        if (op == 5) begin
            busy_n = 0;
            cyc    = 0;
            seen   = 1'b0;
            while (cyc < 100 && !seen) begin
                @(negedge Clock);
                if (bus.Done) begin
                    seen = 1'b1;
                end else begin
                    if (bus.Busy) busy_n++;
                    if (cyc == spoil) begin
                        bus.Start   = 1'b1;
                        bus.Op      = 3'd0;
                        bus.A       = W'($urandom);
                        bus.B       = W'($urandom);
                        bus.AInvert = 1'($urandom);
                    end else begin
                        bus.Start = 1'b0;
                    end
                    if (cyc == abort) begin
                        ResetN = 1'b0;
                        #1;
                        chk("abort_busy", bus.Busy, 0);
                        chk("abort_done", bus.Done, 0);
                        chk("abort_result", bus.Result, 0);
                        chk("abort_flags", {bus.Zero, bus.CarryOut, bus.Overflow}, 0);
                        void'(q.pop_back());
                        @(negedge Clock);
                        @(negedge Clock);
                        ResetN = 1'b1;
                        return;
                    end
                    cyc++;
                end
            end
            chk("mul_done_seen", seen, 1);
            chk("mul_busy_cycles", busy_n, W);
            chk("mul_busy_at_done", bus.Busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        ResetN      = 1'b0;
        bus.Start   = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.AInvert = 1'b0;
        bus.BInvert = 1'b0;
        bus.Op      = 3'd0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_result", bus.Result, 0);
        chk("rst_zero", bus.Zero, 0);
        chk("rst_carry", bus.CarryOut, 0);
        chk("rst_ovf", bus.Overflow, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);

        // ADD wrap to zero, single Done pulse
        issue(2, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, -1, -1);
        @(negedge Clock);
        chk("add_wrap_result", bus.Result, 24'h000000);
        chk("add_wrap_zero", bus.Zero, 1);
        chk("add_wrap_carry", bus.CarryOut, 1);
        chk("add_wrap_ovf", bus.Overflow, 0);
        chk("add_wrap_done", bus.Done, 1);
        @(negedge Clock);
        chk("add_wrap_done_once", bus.Done, 0);

        issue(2, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, -1, -1);
        @(negedge Clock);
        chk("add_ovf_result", bus.Result, 24'h800000);
        chk("add_ovf_flag", bus.Overflow, 1);

        issue(2, 24'd5, 24'd7, 1'b0, 1'b1, -1, -1);
        @(negedge Clock);
        chk("sub_result", bus.Result, 24'hFFFFFE);
        chk("sub_carry", bus.CarryOut, 0);

        issue(3, 24'hFFFFFD, 24'd2, 1'b0, 1'b1, -1, -1);
        @(negedge Clock);
        chk("slt_neg_result", bus.Result, 1);
        issue(3, 24'd2, 24'hFFFFFD, 1'b0, 1'b1, -1, -1);
        @(negedge Clock);
        chk("slt_pos_result", bus.Result, 0);
        chk("slt_pos_zero", bus.Zero, 1);

        // MUL with a stray Start at cycle 10 that must be ignored
        issue(5, 24'd1000, 24'd3000, 1'b0, 1'b0, 10, -1);
        chk("mul_result", bus.Result, 24'h2DC6C0);
        chk("mul_ovf", bus.Overflow, 0);

        issue(5, 24'h001000, 24'h001000, 1'b0, 1'b0, -1, -1);
        chk("mul_big_result", bus.Result, 0);
        chk("mul_big_zero", bus.Zero, 1);
        chk("mul_big_ovf", bus.Overflow, 1);

        // XOR issued in the Done cycle of a MUL
        issue(5, 24'd7, 24'd9, 1'b0, 1'b0, -1, -1);
        issue(4, 24'hAAAAAA, 24'h555555, 1'b0, 1'b0, -1, -1);
        @(negedge Clock);
        chk("b2b_xor_result", bus.Result, 24'hFFFFFF);

        // Reset at MUL cycle 12 aborts without a Done
        @(negedge Clock);
        issue(5, 24'd123, 24'd456, 1'b0, 1'b0, -1, 12);
        repeat (30) @(negedge Clock);
        chk("abort_no_pending", q.size(), 0);

        for (int i = 0; i < 60; i++) begin
            int o;
            o = ($urandom_range(0, 5) == 0) ? 5 : int'($urandom_range(0, 7));
            issue(o, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1, -1);
        end

        repeat (3) @(negedge Clock);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
